// File: rtl/dm_ctrl_pkg.sv
// Shared definitions for the data-memory sequencer: DMType codes, FSM state
// encoding, the type-to-beat-count decode and the load-data extension.
package dm_ctrl_pkg;

  localparam logic [2:0] DM_WORD          = 3'b000;
  localparam logic [2:0] DM_HALF_SIGNED   = 3'b001;
  localparam logic [2:0] DM_HALF_UNSIGNED = 3'b010;
  localparam logic [2:0] DM_BYTE_SIGNED   = 3'b011;
  localparam logic [2:0] DM_BYTE_UNSIGNED = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Number of byte beats for a DMType; 0 marks an illegal type.
  function automatic logic [2:0] dm_beats(input logic [2:0] t);
    case (t)
      DM_WORD:                          return 3'd4;
      DM_HALF_SIGNED, DM_HALF_UNSIGNED: return 3'd2;
      DM_BYTE_SIGNED, DM_BYTE_UNSIGNED: return 3'd1;
      default:                          return 3'd0;
    endcase
  endfunction

  // Sign/zero extension of the assembled little-endian load value.
  function automatic logic [31:0] dm_extend(input logic [2:0] t, input logic [31:0] v);
    case (t)
      DM_HALF_SIGNED:   return {{16{v[15]}}, v[15:0]};
      DM_HALF_UNSIGNED: return {16'h0000, v[15:0]};
      DM_BYTE_SIGNED:   return {{24{v[7]}}, v[7:0]};
      DM_BYTE_UNSIGNED: return {24'h000000, v[7:0]};
      default:          return v;
    endcase
  endfunction

endpackage

// File: rtl/dm_rr_arb.sv
// Two-way round-robin arbiter: a lone requester wins outright, a tie goes to
// the requester that was not granted last. Grant is one-hot, zero when disabled.
module dm_rr_arb (
  input  logic [1:0] req_valid,
  input  logic       enable,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Combinational grant selection.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (&req_valid) grant = last_grant ? 2'b01 : 2'b10;
      else            grant = req_valid;
    end
  end

endmodule

// File: rtl/dm_seq_ctrl.sv
// Data-memory sequencer/arbiter: shares one single-port byte RAM between two
// requesters, splits word/half accesses into little-endian byte beats and
// assembles extended load data.
// Optional feature: define DM_MISALIGN_TRAP_EN to reject misaligned halfword
// and word accesses with resp_err instead of running them byte by byte.
module dm_seq_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_we,
  input  logic [5:0]      req_type,
  input  logic [2*AW-1:0] req_addr,
  input  logic [63:0]     req_wdata,
  output logic [1:0]      resp_valid,
  output logic [31:0]     resp_rdata,
  output logic            resp_err,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [7:0]      mem_wdata,
  input  logic [7:0]      mem_rdata
);

  state_t          state_q, state_d;
  logic [1:0]      grant;
  logic            acc, sel, last_grant_q;
  logic [2:0]      sel_type, acc_beats;
  logic [AW-1:0]   sel_addr;
  logic            acc_misal, acc_err, last_beat;

  logic            grant_q, we_q, err_q, rd_pend_q;
  logic [2:0]      type_q, nbeat_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q, asm_q, rdata_hold_q;
  logic [1:0]      beat_q, rd_idx_q;

  dm_rr_arb u_arb (
    .req_valid  (req_valid),
    .enable     (state_q == ST_IDLE),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign req_ready = grant;
  assign acc       = |grant;
  assign sel       = grant[1];
  assign sel_type  = sel ? req_type[5:3] : req_type[2:0];
  assign sel_addr  = sel ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
  assign acc_beats = dm_beats(sel_type);

`ifdef DM_MISALIGN_TRAP_EN
  assign acc_misal = ((acc_beats == 3'd2) && sel_addr[0]) ||
                     ((acc_beats == 3'd4) && (sel_addr[1:0] != 2'b00));
`else
  assign acc_misal = 1'b0;
`endif

  assign acc_err   = (acc_beats == 3'd0) || acc_misal;
  assign last_beat = ({1'b0, beat_q} == (nbeat_q - 3'd1));

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values and the order of statements cannot change behaviour.
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and all memory/response outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path through
    // the block leaves a value unassigned (which would infer a latch).
    state_d    = state_q;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 8'h00;
    resp_valid = 2'b00;
    resp_err   = 1'b0;
    resp_rdata = rdata_hold_q;
    case (state_q)
      ST_IDLE: begin
        if (acc) state_d = acc_err ? ST_RESP : ST_BEAT;
      end
      ST_BEAT: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q + AW'(beat_q);
        mem_wdata = wdata_q[{beat_q, 3'b000} +: 8];
        if (last_beat) state_d = we_q ? ST_RESP : ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_RESP;
      ST_RESP: begin
        resp_valid = grant_q ? 2'b10 : 2'b01;
        resp_err   = err_q;
        resp_rdata = (err_q || we_q) ? 32'h0 : dm_extend(type_q, asm_q);
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, beat counter, load-byte capture and response hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      type_q       <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      nbeat_q      <= 3'd0;
      err_q        <= 1'b0;
      beat_q       <= 2'd0;
      rd_pend_q    <= 1'b0;
      rd_idx_q     <= 2'd0;
      asm_q        <= 32'h0;
      rdata_hold_q <= 32'h0;
    end else begin
      if (acc) begin
        last_grant_q <= sel;
        grant_q      <= sel;
        we_q         <= sel ? req_we[1] : req_we[0];
        type_q       <= sel_type;
        addr_q       <= sel_addr;
        wdata_q      <= sel ? req_wdata[63:32] : req_wdata[31:0];
        nbeat_q      <= acc_beats;
        err_q        <= acc_err;
        beat_q       <= 2'd0;
        asm_q        <= 32'h0;
      end
      if (state_q == ST_BEAT) beat_q <= beat_q + 2'd1;
      // RAM read data arrives the cycle after the beat that requested it.
      rd_pend_q <= (state_q == ST_BEAT) && !we_q;
      rd_idx_q  <= beat_q;
      if (rd_pend_q) asm_q[{rd_idx_q, 3'b000} +: 8] <= mem_rdata;
      if (state_q == ST_RESP) rdata_hold_q <= resp_rdata;
    end
  end

endmodule
